// File: rtl/video2ram.sv
// video2ram: counts source pixels/lines, writes the active window into the circular line buffer and primes the reader.
module video2ram #(
    parameter int BUFFER_LINE_LENGTH = 640,
    parameter int RAM_NUMWORDS       = 20480,
    parameter int RAM_ADDRESS_BITS   = 15,
    parameter int H_CAPTURE_START    = 0,
    parameter int V_CAPTURE_START    = 0,
    parameter int ACTIVE_LINES       = 480,
    parameter int TRIGGER_LINE       = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [23:0]                 in_data,
    input  logic                        in_valid,
    input  logic                        in_hsync,
    input  logic                        in_vsync,
    input  logic                        line_doubler,
    input  logic                        resync,
    output logic [RAM_ADDRESS_BITS-1:0] wraddr,
    output logic [23:0]                 wrdata,
    output logic                        wren,
    output logic                        starttrigger,
    output logic                        capturing
);
    localparam int AW = RAM_ADDRESS_BITS;
    localparam logic [11:0] H_LO       = 12'(H_CAPTURE_START);
    localparam logic [11:0] H_LEN      = 12'(BUFFER_LINE_LENGTH);
    localparam logic [11:0] V_LO       = 12'(V_CAPTURE_START);
    localparam logic [11:0] TRIG       = 12'(TRIGGER_LINE);
    localparam logic [11:0] LINES_FULL = 12'(ACTIVE_LINES);
    localparam logic [11:0] LINES_HALF = 12'(ACTIVE_LINES / 2);
    localparam logic [AW:0] LINE_STEP  = (AW+1)'(BUFFER_LINE_LENGTH);
    localparam logic [AW:0] NUM_WORDS  = (AW+1)'(RAM_NUMWORDS);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t          state_q, state_d;
    logic            hsync_q, vsync_q;
    logic [11:0]     x_q, x_d, y_q, y_d;
    logic [11:0]     lines_done_q, lines_done_d, lines_max_q, lines_max_d;
    logic [AW-1:0]   line_base_q, line_base_d;
    logic            triggered_q, triggered_d;
    logic            wren_q, wren_d, starttrigger_q, starttrigger_d, capturing_q, capturing_d;
    logic [AW-1:0]   wraddr_q, wraddr_d;
    logic [23:0]     wrdata_q, wrdata_d;
    logic            hs_fall, vs_fall, in_win;
    logic [11:0]     x_cur, y_cur, x_off, lines_inc;
    logic [AW:0]     base_sum;

    // y >= V_LO written so that it stays a real comparison when V_LO is zero
    function automatic logic y_in_window(input logic [11:0] y);
        return ({1'b0, y} + 13'd1) > {1'b0, V_LO};
    endfunction

    always_comb begin
        hs_fall        = hsync_q & ~in_hsync;
        vs_fall        = vsync_q & ~in_vsync;
        x_cur          = hs_fall ? 12'd0 : x_q;
        y_cur          = vs_fall ? 12'd0 : (hs_fall && y_q != 12'hfff) ? y_q + 12'd1 : y_q;
        x_d            = (in_valid && x_cur != 12'hfff) ? x_cur + 12'd1 : x_cur;
        y_d            = y_cur;
        x_off          = x_cur - H_LO;
        lines_inc      = lines_done_q + 12'd1;
        base_sum       = {1'b0, line_base_q} + LINE_STEP;
        state_d        = state_q;
        line_base_d    = line_base_q;
        lines_done_d   = lines_done_q;
        lines_max_d    = lines_max_q;
        triggered_d    = triggered_q;
        starttrigger_d = 1'b0;
        if (vs_fall) begin
            state_d      = ACTIVE;
            line_base_d  = '0;
            lines_done_d = '0;
            triggered_d  = 1'b0;
            lines_max_d  = line_doubler ? LINES_HALF : LINES_FULL;
        end else if (state_q == ACTIVE && hs_fall && y_in_window(y_q)) begin
            line_base_d  = (base_sum >= NUM_WORDS) ? '0 : base_sum[AW-1:0];
            lines_done_d = lines_inc;
            if (lines_inc == TRIG && !triggered_q) begin
                starttrigger_d = 1'b1;
                triggered_d    = 1'b1;
            end
            if (lines_inc == lines_max_q) state_d = DONE;
        end
        if (resync) begin
            state_d        = IDLE;
            line_base_d    = '0;
            triggered_d    = 1'b0;
            starttrigger_d = 1'b0;
        end
        // x_off wraps to a large value left of the window, so one compare covers both bounds
        in_win      = in_valid && state_d == ACTIVE && x_off < H_LEN && y_in_window(y_cur);
        wren_d      = in_win;
        wraddr_d    = in_win ? line_base_d + AW'(x_off) : wraddr_q;
        wrdata_d    = in_win ? in_data : wrdata_q;
        capturing_d = state_d == ACTIVE;
    end

    always_ff @(posedge clock) begin
        hsync_q <= in_hsync;
        vsync_q <= in_vsync;
        if (!reset) begin
            state_q        <= IDLE;
            x_q            <= '0;
            y_q            <= '0;
            lines_done_q   <= '0;
            lines_max_q    <= '0;
            line_base_q    <= '0;
            triggered_q    <= 1'b0;
            wren_q         <= 1'b0;
            starttrigger_q <= 1'b0;
            capturing_q    <= 1'b0;
            wraddr_q       <= '0;
            wrdata_q       <= '0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            lines_done_q   <= lines_done_d;
            lines_max_q    <= lines_max_d;
            line_base_q    <= line_base_d;
            triggered_q    <= triggered_d;
            wren_q         <= wren_d;
            starttrigger_q <= starttrigger_d;
            capturing_q    <= capturing_d;
            wraddr_q       <= wraddr_d;
            wrdata_q       <= wrdata_d;
        end
    end

    assign wraddr       = wraddr_q;
    assign wrdata       = wrdata_q;
    assign wren         = wren_q;
    assign starttrigger = starttrigger_q;
    assign capturing    = capturing_q;
endmodule

// File: tb/tb_video2ram.sv
// tb_video2ram: line-level table plus randomized lines checked against a frame/line reference model.
module tb_video2ram;
    localparam int BLL = 8, NW = 32, AW = 5, HCS = 2, VCS = 1, AL = 6, TL = 2;

    logic          clock = 1'b0, reset = 1'b0;
    logic [23:0]   in_data = '0;
    logic          in_valid = 1'b0, in_hsync = 1'b1, in_vsync = 1'b1, line_doubler = 1'b0, resync = 1'b0;
    logic [AW-1:0] wraddr;
    logic [23:0]   wrdata;
    logic          wren, starttrigger, capturing;

    video2ram #(
        .BUFFER_LINE_LENGTH(BLL), .RAM_NUMWORDS(NW), .RAM_ADDRESS_BITS(AW),
        .H_CAPTURE_START(HCS), .V_CAPTURE_START(VCS), .ACTIVE_LINES(AL), .TRIGGER_LINE(TL)
    ) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .line_doubler(line_doubler), .resync(resync),
        .wraddr(wraddr), .wrdata(wrdata), .wren(wren), .starttrigger(starttrigger), .capturing(capturing)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit fs; int npix; bit gaps; bit dbl; int rs; int rr;
        int wr; int tr; bit cap;
    } line_t;

    int n_tests = 0, n_fail = 0;
    bit m_act, m_trig;
    int m_y = 0, m_done = 0, m_base = 0, m_lmax = 0;
    int line_wr, line_tr;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One source line: hsync falls on cycle 0 (with vsync when fs), then pixels, then blanking.
    task automatic send_line(input bit fs, input int npix, input bit gaps, input bit dbl,
                             input int rs, input int rr, input bit tabd);
        int ncyc = (gaps ? 2 * npix : npix) + 3;
        int x = 0;
        bit v, ew, et;
        int ea;
        line_wr = 0;
        line_tr = 0;
        for (int c = 0; c < ncyc; c++) begin
            v = (x < npix) && (!gaps || c % 2 == 0);
            et = 1'b0;
            if (c == 0) begin
                if (fs) begin
                    m_act = 1'b1; m_base = 0; m_done = 0; m_trig = 1'b0; m_y = 0;
                    m_lmax = dbl ? AL / 2 : AL;
                end else begin
                    if (m_act && m_y >= VCS) begin
                        m_done++;
                        m_base = (m_base + BLL) % NW;
                        if (m_done == TL && !m_trig) begin et = 1'b1; m_trig = 1'b1; end
                        if (m_done == m_lmax) m_act = 1'b0;
                    end
                    m_y = (m_y < 4095) ? m_y + 1 : 4095;
                end
            end
            if (c == rs) begin m_act = 1'b0; m_base = 0; m_trig = 1'b0; et = 1'b0; end
            in_hsync     = (c != 0);
            in_vsync     = !(fs && c == 0);
            line_doubler = dbl;
            resync       = (c == rs);
            reset        = (c != rr);
            in_valid     = v;
            in_data      = tabd ? 24'(m_y * 16 + x) : 24'($urandom);
            ew = v && m_act && x >= HCS && x < HCS + BLL && m_y >= VCS;
            ea = m_base + x - HCS;
            @(posedge clock);
            #1;
            if (c == rr) begin
                check("rst_wren", int'(wren), 0);
                check("rst_trig", int'(starttrigger), 0);
                check("rst_capturing", int'(capturing), 0);
                check("rst_wraddr", int'(wraddr), 0);
                check("rst_wrdata", int'(wrdata), 0);
                m_act = 1'b0; m_base = 0; m_trig = 1'b0; m_done = 0; m_y = 0;
                x = 0;
            end else begin
                check("wren", int'(wren), int'(ew));
                check("starttrigger", int'(starttrigger), int'(et));
                check("capturing", int'(capturing), int'(m_act));
                if (ew && wren) begin
                    check("wraddr", int'(wraddr), ea);
                    check("wrdata", int'(wrdata), int'(in_data));
                end
                if (v) x++;
            end
            line_wr += int'(wren);
            line_tr += int'(starttrigger);
        end
        resync = 1'b0;
        reset  = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        line_t tab[25];
        tab[0]  = '{1, 12, 0, 0, -1, -1, 0, 0, 1};
        tab[1]  = '{0, 12, 0, 0, -1, -1, 8, 0, 1};
        tab[2]  = '{0, 12, 0, 0, -1, -1, 8, 0, 1};
        tab[3]  = '{0, 12, 0, 0, -1, -1, 8, 1, 1};
        tab[4]  = '{0, 12, 0, 0, -1, -1, 8, 0, 1};
        tab[5]  = '{0, 12, 0, 0, -1, -1, 8, 0, 1};
        tab[6]  = '{0, 12, 0, 0, -1, -1, 8, 0, 1};
        tab[7]  = '{0, 12, 0, 0, -1, -1, 0, 0, 0};
        tab[8]  = '{0, 12, 0, 0, -1, -1, 0, 0, 0};
        tab[9]  = '{1, 12, 0, 1, -1, -1, 0, 0, 1};
        tab[10] = '{0, 5,  0, 1, -1, -1, 3, 0, 1};
        tab[11] = '{0, 12, 1, 0, -1, -1, 8, 0, 1};
        tab[12] = '{0, 12, 0, 0, -1, -1, 8, 1, 1};
        tab[13] = '{0, 12, 0, 0, -1, -1, 0, 0, 0};
        tab[14] = '{1, 12, 0, 0, -1, -1, 0, 0, 1};
        tab[15] = '{0, 12, 0, 0, 6,  -1, 4, 0, 0};
        tab[16] = '{0, 12, 0, 0, -1, -1, 0, 0, 0};
        tab[17] = '{1, 12, 0, 0, -1, -1, 0, 0, 1};
        tab[18] = '{0, 12, 0, 0, -1, -1, 8, 0, 1};
        tab[19] = '{0, 12, 0, 0, -1, -1, 8, 0, 1};
        tab[20] = '{0, 12, 0, 0, -1, -1, 8, 1, 1};
        tab[21] = '{0, 12, 0, 0, -1, 5,  3, 0, 0};
        tab[22] = '{0, 12, 0, 0, -1, -1, 0, 0, 0};
        tab[23] = '{1, 12, 0, 0, -1, -1, 0, 0, 1};
        tab[24] = '{0, 12, 0, 0, -1, -1, 8, 0, 1};

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_wren", int'(wren), 0);
        check("reset_trig", int'(starttrigger), 0);
        check("reset_capturing", int'(capturing), 0);
        check("reset_wraddr", int'(wraddr), 0);
        check("reset_wrdata", int'(wrdata), 0);
        reset = 1'b1;
        m_act = 1'b0;
        m_trig = 1'b0;

        for (int i = 0; i < 25; i++) begin
            send_line(tab[i].fs, tab[i].npix, tab[i].gaps, tab[i].dbl, tab[i].rs, tab[i].rr, 1'b1);
            check($sformatf("line%0d_writes", i), line_wr, tab[i].wr);
            check($sformatf("line%0d_triggers", i), line_tr, tab[i].tr);
            check($sformatf("line%0d_capturing", i), int'(capturing), int'(tab[i].cap));
        end

        for (int i = 0; i < 80; i++) begin
            bit fs = (i == 0) || ($urandom_range(0, 4) == 0);
            int npix = $urandom_range(0, 12);
            bit gaps = $urandom_range(0, 1) == 1;
            int ncyc = (gaps ? 2 * npix : npix) + 3;
            int rs = ($urandom_range(0, 14) == 0) ? $urandom_range(1, ncyc - 1) : -1;
            int rr = (rs < 0 && $urandom_range(0, 29) == 0) ? $urandom_range(1, ncyc - 1) : -1;
            send_line(fs, npix, gaps, $urandom_range(0, 1) == 1, rs, rr, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/video2ram.md
Name: video2ram

Overview:
- Capture stage directly upstream of the line-buffer RAM reader.
- Takes the decoded source pixel stream (24-bit RGB, pixel-enable, active-low hsync/vsync) and counts source pixels and lines.
- Writes the active window into the circular line-buffer RAM that the output-timing reader consumes.
- Issues the one-cycle starttrigger that starts the output-timing reader once enough lines are buffered.

Parameters:
- BUFFER_LINE_LENGTH, 640: RAM words per buffered line (pixels captured per line).
- RAM_NUMWORDS, 20480: total RAM words. Must be an integer multiple of BUFFER_LINE_LENGTH.
- RAM_ADDRESS_BITS, 15: RAM address width.
- H_CAPTURE_START, 0: index of the first captured pixel after a line start.
- V_CAPTURE_START, 0: index of the first captured line after a frame start.
- ACTIVE_LINES, 480: lines captured per frame when line_doubler=0.
- TRIGGER_LINE, 8: completed captured lines before starttrigger fires.

Ports:
- clock  in  1  capture clock.
- reset  in  1  synchronous, active-low reset.
- in_data  in  24  source pixel, {R,G,B}.
- in_valid  in  1  pixel enable; in_data is valid this cycle.
- in_hsync  in  1  source hsync, active-low.
- in_vsync  in  1  source vsync, active-low.
- line_doubler  in  1  1: 240-line source, so capture ACTIVE_LINES/2.
- resync  in  1  force realignment (driven by the reader's restart).
- wraddr  out  RAM_ADDRESS_BITS  RAM write address.
- wrdata  out  24  RAM write data.
- wren  out  1  RAM write enable.
- starttrigger  out  1  one-cycle pulse; buffer primed.
- capturing  out  1  high while in ACTIVE state.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clock edge): state IDLE, wren=0, starttrigger=0, capturing=0, wraddr=0, wrdata=0, x=0, y=0, line_base=0, lines_done=0, triggered=0.
- Edge detection: previous hsync/vsync are registered. hs_fall = prev_hsync & ~in_hsync; vs_fall likewise for vsync.
- Counters:
  - x (12b): on hs_fall, x<=1 if in_valid, else x<=0. The pixel valid on the edge cycle is x=0. Otherwise x increments on in_valid and saturates at 4095.
  - y (12b): on vs_fall, y<=0. Else on hs_fall, y<=y+1, saturating. Simultaneous vs_fall and hs_fall: vs_fall wins, y=0.
- lines_max = line_doubler ? ACTIVE_LINES/2 : ACTIVE_LINES, sampled on vs_fall only. A mid-frame toggle takes effect next frame.
- States:
  - IDLE: no writes. On vs_fall: line_base<=0, lines_done<=0, triggered<=0, go ACTIVE.
  - ACTIVE: capturing=1.
    - Capture window: in_valid, H_CAPTURE_START <= x < H_CAPTURE_START+BUFFER_LINE_LENGTH, and V_CAPTURE_START <= y.
    - In the window, the next cycle has wren=1, wrdata=in_data, wraddr=line_base+(x-H_CAPTURE_START). Latency is 1 cycle.
    - Pixels beyond the line length are dropped.
    - On hs_fall ending a window line (y >= V_CAPTURE_START):
      - line_base <= line_base+BUFFER_LINE_LENGTH, or 0 if that sum is >= RAM_NUMWORDS (wrap).
      - lines_done++.
    - A short line (hsync before all pixels arrive) still advances line_base. The unwritten words keep stale data.
    - When lines_done becomes TRIGGER_LINE and triggered=0: starttrigger=1 for exactly the next cycle, and triggered<=1.
    - When lines_done reaches lines_max: go DONE.
    - A vs_fall in ACTIVE before lines_max restarts the frame as in IDLE. The trigger may fire again.
  - DONE: no writes, capturing=0. On vs_fall, do the IDLE-entry actions and go ACTIVE.
- resync=1 (any state): next cycle state=IDLE, wren=0, starttrigger=0, line_base=0, triggered=0. resync has priority below reset and above everything else.
- Reset mid-line: any write in progress is abandoned, and wren=0 on the following cycle.
- Address arithmetic is RAM_ADDRESS_BITS wide. line_base+offset never exceeds RAM_NUMWORDS-1 by construction.

Test Plan:
Bench parameters for all scenarios: BUFFER_LINE_LENGTH=8, RAM_NUMWORDS=32, RAM_ADDRESS_BITS=5, H_CAPTURE_START=2, V_CAPTURE_START=1, ACTIVE_LINES=6, TRIGGER_LINE=2.
- Basic capture:
  - Stimulus: vs_fall, then lines of 12 valid pixels, data = y*16+x.
  - Required: line y=0 gives no writes. Line y=1 gives wraddr 0..7 with data 0x12..0x19, each 1 cycle after its input.
- Trigger:
  - Stimulus: continue the basic frame.
  - Required: starttrigger is a single-cycle pulse on the cycle after the hs_fall ending line y=2, and only once per frame.
- Wrap and DONE:
  - Stimulus: 6 captured lines.
  - Required: line_base runs 0, 8, 16, 24, 0, 8. After the 6th line, capturing=0 and no wren until the next vs_fall.
- Line doubler:
  - Stimulus: line_doubler=1, set before vs_fall.
  - Required: DONE after 3 lines.
  - Stimulus: toggle line_doubler mid-frame.
  - Required: that frame still captures the count latched at its vs_fall.
- Short line and gaps:
  - Stimulus: a line with only 5 valid pixels, and in_valid toggling every other cycle.
  - Required: offsets 0..2 are written and line_base still advances by 8. No wren occurs on in_valid=0 cycles.
- Resync and reset:
  - Stimulus: assert resync mid-line.
  - Required: wren=0 next cycle and IDLE until vs_fall, then capture restarts at wraddr 0 and the trigger re-fires.
  - Stimulus: reset=0 for one cycle.
  - Required: all outputs are 0.
  - Stimulus: simultaneous vs_fall and hs_fall.
  - Required: y=0.
